// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Rotate left by s: result[i] = v[(i - s) mod N_REQ].
  function automatic logic [N_REQ-1:0] rotl(input logic [N_REQ-1:0] v,
                                            input logic [IDX_W-1:0] s);
    logic [2*N_REQ-1:0] d;
    d = {v, v} << s;
    return d[2*N_REQ-1:N_REQ];
  endfunction

endpackage

// File: rtl/arb_4_rr_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Optional lock signal exists only when ARB_LOCK_EN is defined.
interface arb_4_rr_if;
  import arb_pkg::*;

  // req is a level held by each requester for as long as it wants the
  // resource; gnt answers one cycle later and stays until the owner drops
  // req, pulses done for one cycle, or the hold limit fires timeout.
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;
`ifdef ARB_LOCK_EN
  logic             lock;

  modport master (output req, done, lock, input gnt, gnt_idx, gnt_vld, timeout);
  modport slave  (input req, done, lock, output gnt, gnt_idx, gnt_vld, timeout);
`else
  modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, timeout);
`endif

endinterface

// File: rtl/enc_4_2_oh.sv
// Combinational one-hot to binary encoder; all-zero input gives vld=0, idx=0.
module enc_4_2_oh
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] oh,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  assign idx = {oh[3] | oh[2], oh[3] | oh[1]};
  assign vld = |oh;

endmodule

// File: rtl/arb_4_rr.sv
// 4-requester round-robin arbiter with done/req-drop/hold-limit release.
// Optional ARB_LOCK_EN adds a lock input that pins the current grant.
module arb_4_rr
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4,
  parameter int PTR_INIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  arb_4_rr_if.slave  bus,
  output arb_state_t dbg_state
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] nxt_idx;
  logic [HOLD_W-1:0] hold;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rot_req;
  logic [N_REQ-1:0] rot_pick;
  logic [N_REQ-1:0] nxt_gnt;
  logic             nxt_vld;
  logic             lock_on;
  logic             owner_req;
  logic             done_rel;
  logic             limit_hit;
  logic             rel;

`ifdef ARB_LOCK_EN
  assign lock_on = bus.lock;
`else
  assign lock_on = 1'b0;
`endif

  // Rotate so bit 0 is requester ptr+1, take the lowest set bit, rotate back.
  assign rot_req  = rotl(bus.req, IDX_W'(N_REQ - 1) - ptr);
  assign rot_pick = rot_req & (~rot_req + N_REQ'(1));
  assign nxt_gnt  = rotl(rot_pick, ptr + IDX_W'(1));

  enc_4_2_oh u_enc (
    .oh  (nxt_gnt),
    .idx (nxt_idx),
    .vld (nxt_vld)
  );

  assign owner_req = |(bus.req & gnt_q);
  assign done_rel  = bus.done & ~lock_on;
  assign limit_hit = (MAX_HOLD != 0) && (hold == HOLD_LAST) && !lock_on;
  assign rel       = done_rel | ~owner_req | limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= IDX_W'(PTR_INIT);
      hold  <= '0;
      gnt_q <= '0;
      idx_q <= '0;
    end else if (state == ST_IDLE) begin
      if (nxt_vld) begin
        gnt_q <= nxt_gnt;
        idx_q <= nxt_idx;
        hold  <= '0;
        state <= ST_GRANT;
      end
    end else begin
      if (rel) begin
        ptr   <= idx_q;
        gnt_q <= '0;
        hold  <= '0;
        state <= ST_IDLE;
      end else if (!lock_on && hold != HOLD_SAT) begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end

  // done in the same cycle as the limit wins, so timeout stays low then.
  assign bus.timeout = (state == ST_GRANT) && limit_hit && !bus.done;
  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = |gnt_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_arb_4_rr.sv
// Directed self-checking bench for arb_4_rr; lock checks run when ARB_LOCK_EN is defined.
module tb_arb_4_rr;
  import arb_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;
  int         n_checks;
  int         n_pass;
  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] exp_owner;

  arb_4_rr_if bus ();

  arb_4_rr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // driver tasks
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // idle after reset
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      check("reset_idle", {bus.gnt, bus.gnt_vld, bus.timeout}, 32'h0);
      check("reset_state", dbg_state, ST_IDLE);
    end

    // full request set with done two cycles after each grant
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_owner = exp_q.pop_front();
      next_cycle();
      check("rr_gnt", bus.gnt, 32'(4'b0001 << exp_owner));
      check("rr_idx", bus.gnt_idx, exp_owner);
      next_cycle();
      bus.done = 1'b1;
      next_cycle();
      bus.done = 1'b0;
      check("rr_bubble", {bus.gnt, bus.gnt_vld}, 32'h0);
      if (k == 4) bus.req = 4'b0000;
    end

    // hold limit: 15 grant cycles, timeout on the last, bubble, regrant
    next_cycle();
    bus.req = 4'b0100;
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      check("hold_gnt", bus.gnt, 32'h4);
      check("hold_timeout", bus.timeout, (c == 15) ? 32'h1 : 32'h0);
    end
    next_cycle();
    check("hold_bubble", bus.gnt, 32'h0);
    next_cycle();
    check("hold_regrant", bus.gnt, 32'h4);

    // req drop mid-grant, then pointer continues after owner 1
    bus.req = 4'b0000;
    next_cycle();
    check("drop2_gnt", bus.gnt, 32'h0);
    bus.req = 4'b0010;
    next_cycle();
    check("own1_gnt", bus.gnt, 32'h2);
    bus.req = 4'b0000;
    next_cycle();
    check("drop1_gnt", bus.gnt, 32'h0);
    bus.req = 4'b1010;
    next_cycle();
    check("after1_gnt", bus.gnt, 32'h8);
    check("after1_idx", bus.gnt_idx, 32'h3);

    // asynchronous reset mid-grant
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", {bus.gnt, bus.gnt_vld}, 32'h0);
    check("async_state", dbg_state, ST_IDLE);
    next_cycle();
    rst_n = 1'b1;
    bus.req = 4'b0001;
    next_cycle();
    check("post_rst_gnt", bus.gnt, 32'h1);

    // done and limit in the same cycle: done wins, no timeout
    bus.req = 4'b0000;
    next_cycle();
    check("drop0_gnt", bus.gnt, 32'h0);
    bus.req = 4'b0100;
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      if (c == 15) begin
        bus.done = 1'b1;
        #1;
        check("done_wins_timeout", bus.timeout, 32'h0);
        check("done_wins_gnt", bus.gnt, 32'h4);
      end
    end
    next_cycle();
    bus.done = 1'b0;
    check("done_wins_bubble", bus.gnt, 32'h0);
    next_cycle();
    check("regrant2_gnt", bus.gnt, 32'h4);

`ifdef ARB_LOCK_EN
    bus.lock = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.done = c[0];
      next_cycle();
      check("lock_gnt", bus.gnt, 32'h4);
      check("lock_timeout", bus.timeout, 32'h0);
    end
    bus.lock = 1'b0;
    bus.done = 1'b1;
    bus.req  = 4'b0000;
    next_cycle();
    bus.done = 1'b0;
    check("unlock_release", bus.gnt, 32'h0);
`endif

    bus.req = 4'b0000;
    next_cycle();
    next_cycle();
    check("final_idle", {bus.gnt, bus.gnt_vld}, 32'h0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
